// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: GF(2^8) helpers for the InvMixColumns
// coefficients, engine FSM state encoding and datapath widths.
package aes_pkg;

    localparam int         COL_W    = 32;
    localparam int         STATE_W  = 128;
    localparam int         NUM_COLS = STATE_W / COL_W;
    localparam logic [7:0] GF_POLY  = 8'h1B;   // low byte of x^8+x^4+x^3+x+1

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Multiply by x in GF(2^8), folding the carry back in with the reduction byte.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // The four inverse coefficients share one xtime chain of depth 3:
    // 09 = x3^1, 0b = x3^x1^1, 0d = x3^x2^1, 0e = x3^x2^x1.
    function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
        logic [7:0] x1, x2, x3;
        x1 = xtime(b);
        x2 = xtime(x1);
        x3 = xtime(x2);
        return x3 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
        logic [7:0] x1, x2, x3;
        x1 = xtime(b);
        x2 = xtime(x1);
        x3 = xtime(x2);
        return x3 ^ x1 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
        logic [7:0] x1, x2, x3;
        x1 = xtime(b);
        x2 = xtime(x1);
        x3 = xtime(x2);
        return x3 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
        logic [7:0] x1, x2, x3;
        x1 = xtime(b);
        x2 = xtime(x1);
        x3 = xtime(x2);
        return x3 ^ x2 ^ x1;
    endfunction

endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// Valid/ready bus carrying a full AES state into and out of the engine.
interface inv_mix_columns_iter_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] state_in;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] state_out;

    // Upstream/downstream side that feeds states and takes results.
    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out
    );

    // Engine side.
    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out
    );

endinterface

// File: rtl/inv_mix_col.sv
// Combinational InvMixColumns for one 32-bit column; row 0 byte is the MSB.
module inv_mix_col
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col,
    output logic [COL_W-1:0] mixed
);

    logic [7:0] s [4];

    // Each output row is the same circulant row of coefficients rotated by
    // the row index: 0e on its own byte, then 0b, 0d, 09 on the following ones.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign s[gi] = col[COL_W-1-8*gi -: 8];
        assign mixed[COL_W-1-8*gi -: 8] = gf_mul_0e(s[gi])
                                        ^ gf_mul_0b(s[(gi+1)%4])
                                        ^ gf_mul_0d(s[(gi+2)%4])
                                        ^ gf_mul_09(s[(gi+3)%4]);
    end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns engine: loads a 128-bit state, runs one column per
// clock through a single shared column unit, then holds the result until taken.
module inv_mix_columns_iter
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    inv_mix_columns_iter_if.slave bus
);

    fsm_state_t         state;
    logic [1:0]         col_cnt;
    logic [STATE_W-1:0] work_reg;
    logic [STATE_W-1:0] work_wb;
    logic [COL_W-1:0]   cols [NUM_COLS];
    logic [COL_W-1:0]   col_in;
    logic [COL_W-1:0]   col_out;

    // Split the working state into columns and build the write-back image
    // where only the column currently addressed by col_cnt is replaced.
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
        assign cols[gi] = work_reg[STATE_W-1-COL_W*gi -: COL_W];
        assign work_wb[STATE_W-1-COL_W*gi -: COL_W] =
            (col_cnt == 2'(gi)) ? col_out : cols[gi];
    end

    assign col_in = cols[col_cnt];

    inv_mix_col u_col (
        .col   (col_in),
        .mixed (col_out)
    );

    // Handshake outputs come from the registered state; in DONE the engine can
    // take a new state in the same cycle the current result leaves.
    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign bus.state_out = work_reg;

    // FSM, column counter and working register; col_cnt wraps 3->0 as the
    // last column is written, so it is already 0 for the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            col_cnt  <= 2'd0;
            work_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_reg <= bus.state_in;
                        col_cnt  <= 2'd0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    work_reg <= work_wb;
                    col_cnt  <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            work_reg <= bus.state_in;
                            col_cnt  <= 2'd0;
                            state    <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    col_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Scoreboard bench for inv_mix_columns_iter using known AES column vectors.
module tb_inv_mix_columns_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic prev_ov = 1'b0;

    typedef struct {
        logic [127:0] data;
        int           rise;
    } exp_t;

    exp_t sb[$];

    inv_mix_columns_iter_if bus ();

    inv_mix_columns_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    // Present a state and hold it until accepted; returns the accept edge index.
    task automatic send(input logic [127:0] d, input logic [127:0] e, input bit push, output int acc);
        bit got;
        got = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.state_in = d;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, want 1");
            acc = -1;
        end else begin
            acc = cyc + 1;
            if (push) sb.push_back('{data: e, rise: acc + 4});
            $display("in  cyc=%0d state_in=%h", acc, d);
            @(posedge clk);
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        if (!empty) begin
            total++;
            bad++;
            $display("FAIL result_timeout: %0d results pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: got out_valid=1 state_out=%h, want out_valid=0", bus.state_out);
                    prev_ov = 1'b1;
                end else begin
                    if (!prev_ov) check("latency", 128'(cyc), 128'(sb[0].rise));
                    check("state_out", bus.state_out, sb[0].data);
                    if (bus.out_ready) begin
                        $display("out cyc=%0d state_out=%h", cyc + 1, bus.state_out);
                        void'(sb.pop_front());
                        prev_ov = 1'b0;
                    end else begin
                        prev_ov = 1'b1;
                    end
                end
            end else begin
                prev_ov = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int acc_a, acc_b, acc_c;
        bus.in_valid  = 1'b0;
        bus.state_in  = '0;
        bus.out_ready = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready",  128'(bus.in_ready),  128'(1'b1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
        check("rst_state_out", bus.state_out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle stability.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("idle_out_valid", 128'(bus.out_valid), 128'(1'b0));
            check("idle_state_out", bus.state_out, 128'h0);
        end

        // Directed vectors.
        send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
             128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1, acc_a);
        drop_valid();
        wait_done();
        send(128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6,
             128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5, 1'b1, acc_a);
        drop_valid();
        wait_done();
        send(128'h00000000_00000000_4d7ebdf8_00000000,
             128'h00000000_00000000_2d26314c_00000000, 1'b1, acc_a);
        drop_valid();
        wait_done();
        send(128'h8e4da1bc_d5d5d7d6_4d7ebdf8_9fdc589d,
             128'hdb135345_d4d4d4d5_2d26314c_f20a225c, 1'b1, acc_a);
        drop_valid();
        wait_done();

        // Backpressure: result held, no new accept while stalled.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(128'h9fdc589d_8e4da1bc_c6c6c6c6_01010101,
             128'hf20a225c_db135345_c6c6c6c6_01010101, 1'b1, acc_a);
        drop_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) break;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.state_in = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
            #1;
            check("stall_in_ready",  128'(bus.in_ready),  128'(1'b0));
            check("stall_out_valid", 128'(bus.out_valid), 128'(1'b1));
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_done();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("post_stall_valid", 128'(bus.out_valid), 128'(1'b0));
        end

        // Back-to-back: second state accepted on the edge the first leaves.
        send(128'h01010101_c6c6c6c6_8e4da1bc_9fdc589d,
             128'h01010101_c6c6c6c6_db135345_f20a225c, 1'b1, acc_a);
        send(128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8,
             128'h2d26314c_2d26314c_2d26314c_2d26314c, 1'b1, acc_b);
        drop_valid();
        check("b2b_spacing", 128'(acc_b - acc_a), 128'(5));
        wait_done();

        // Reset while BUSY after column 1 has been written.
        send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b0, acc_c);
        @(negedge clk);                 // after edge k
        bus.in_valid = 1'b0;
        @(negedge clk);                 // after edge k+1: column 0 written
        @(negedge clk);                 // after edge k+2: column 1 written
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(bus.out_valid), 128'(1'b0));
        check("midrst_in_ready",  128'(bus.in_ready),  128'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("after_rst_valid", 128'(bus.out_valid), 128'(1'b0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns_iter.md
# inv_mix_columns_iter

Iterative AES InvMixColumns engine for the decryption datapath, the inverse of the forward MixColumns column logic. It accepts a full 128-bit state over a valid/ready handshake and transforms one 32-bit column per clock through a shared combinational column unit. The result is held on a valid/ready output until it is taken. It sits between InvShiftRows/InvSubBytes/AddRoundKey stages of the inverse cipher round.

## Interface

- No parameters. State width is fixed at 128 bits and column width at 32 bits.
- clk        input   1    rising-edge clock
- rst_n      input   1    reset; asynchronous and active-low
- in_valid   input   1    state_in is valid
- in_ready   output  1    engine can accept a new state
- state_in   input   128  column c occupies bits [127-32c -: 32]; row 0 byte is the column MSB
- out_valid  output  1    state_out holds a completed result
- out_ready  input   1    downstream accepts state_out
- state_out  output  128  InvMixColumns(state_in), same byte layout

## Operation

- Per column, (s0,s1,s2,s3) → (0e·s0^0b·s1^0d·s2^09·s3, 09·s0^0e·s1^0b·s2^0d·s3, 0d·s0^09·s1^0e·s2^0b·s3, 0b·s0^0d·s1^09·s2^0e·s3).
- Multiplication is in GF(2^8), reduced by 0x11B. Build the 09/0b/0d/0e products from chained xtime; no lookup ROM.
- States:
  - IDLE: in_ready=1. An accepted in_valid&in_ready copies state_in into the working register, clears col_cnt to 0, and moves to BUSY.
  - BUSY: each cycle, column col_cnt of the working register passes through the column unit and is written back in place, then col_cnt increments. At col_cnt=3 the write completes and the engine moves to DONE.
  - DONE: out_valid=1 and state_out equals the working register. out_valid&out_ready returns to IDLE.
- col_cnt is 2 bits. It wraps 3→0 only on the BUSY→DONE transition and is never observed outside BUSY.
- Back-to-back: in DONE, in_ready = out_ready. If a transfer and an accept happen in the same cycle, the engine loads the new state and goes directly to BUSY.
- in_valid in BUSY is ignored (in_ready=0). state_in needs to be stable only in the accept cycle.
- out_valid stays asserted and state_out stays stable until out_ready; withholding out_ready is lossless backpressure.
- Asynchronous reset mid-operation abandons any in-flight state with no partial output.

## Timing

- Reset values: in_ready=1, out_valid=0, state_out=128'h0, col_cnt=0, FSM=IDLE.
- With the accept at edge k, columns 0..3 are written at edges k+1..k+4, and out_valid rises after edge k+4 (4-cycle latency).
- Sustained throughput is one state per 5 cycles with out_ready tied high.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid to out_valid.
- The column unit is the critical path: one xtime chain of depth 3 plus XOR trees, within one cycle.

## Structure

- Shared package aes_pkg holds:
  - xtime and gf_mul function definitions for the 09/0b/0d/0e products.
  - The FSM state enum (IDLE, BUSY, DONE).
  - Constants for the 0x1B reduction and the column width.
- One natural sub-module: inv_mix_col, a combinational 32-bit column in to 32-bit column out. It is instantiated once and is unit-testable standalone.

## Test plan

- Single column vector: state_in = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 → state_out = db135345_f20a225c_01010101_c6c6c6c6, out_valid 4 cycles after the accept.
- Round-trip: a state of d5d5d7d6 replicated 4× → d4d4d4d5 replicated 4×. Also 4d7ebdf8 → 2d26314c in column 2 only, with the other columns 00000000 → 00000000.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid stays 1, state_out is stable, in_ready=0, and a new in_valid is not accepted.
- Back-to-back: two states presented, out_ready=1 and in_valid held → the second state is accepted in the same cycle the first is transferred, with results 5 cycles apart.
- Reset mid-BUSY: deassert rst_n after col 1 is written → out_valid=0 and in_ready=1 immediately, and no result appears after reset release.
- Idle stability: in_valid=0 for 20 cycles after reset → out_valid=0 and state_out=0 throughout.
